// File: rtl/alu_issue_sched.sv
// Round-robin issue of two slots onto one shared integer ALU, with a one-entry result register.
// Latency: single-cycle ops 1 clk to res_valid_o; multiply MUL_CYCLES clks (plus stall cycles).
// Backpressure: slots stall while the output entry is full and not draining, or a multiply is in flight.
module alu_issue_sched #(
  parameter int LENGTH     = 32,
  parameter int TAG_W      = 6,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [LENGTH-1:0] req0_a_i,
  input  logic [LENGTH-1:0] req0_b_i,
  input  logic [3:0]        req0_ctrl_i,
  input  logic [TAG_W-1:0]  req0_tag_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [LENGTH-1:0] req1_a_i,
  input  logic [LENGTH-1:0] req1_b_i,
  input  logic [3:0]        req1_ctrl_i,
  input  logic [TAG_W-1:0]  req1_tag_i,
  output logic [LENGTH-1:0] alu_a_o,
  output logic [LENGTH-1:0] alu_b_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [LENGTH-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [LENGTH-1:0] res_data_o,
  output logic              res_zero_o,
  output logic [TAG_W-1:0]  res_tag_o,
  output logic              res_src_o
);

  localparam logic [3:0] CTRL_MUL = 4'h2;
  // Count starts one short: the final busy cycle is the one that loads the result.
  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic [3:0]        count, count_nxt;

  logic [LENGTH-1:0] hold_a, hold_b;
  logic [3:0]        hold_ctrl;
  logic [TAG_W-1:0]  hold_tag;
  logic              hold_src;

  logic              slot_free;
  logic              any_valid;
  logic              win;
  logic [LENGTH-1:0] win_a, win_b;
  logic [3:0]        win_ctrl;
  logic [TAG_W-1:0]  win_tag;

  logic              grant;
  logic              load_res;
  logic              hold_load;
  logic [TAG_W-1:0]  load_tag;
  logic              load_src;

  assign slot_free = !res_valid_o || res_ready_i;

  // Pick the slot that would win arbitration: a lone requester, or the one not granted last on a tie.
  always_comb begin
    any_valid = req0_valid_i || req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      win = ~last_grant;
    end else begin
      win = req1_valid_i;
    end
    win_a    = win ? req1_a_i    : req0_a_i;
    win_b    = win ? req1_b_i    : req0_b_i;
    win_ctrl = win ? req1_ctrl_i : req0_ctrl_i;
    win_tag  = win ? req1_tag_i  : req0_tag_i;
  end

  // Next-state, grant, ALU drive and result-load decisions.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    grant        = 1'b0;
    load_res     = 1'b0;
    hold_load    = 1'b0;
    load_tag     = win_tag;
    load_src     = win;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_ctrl_o   = '0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          alu_a_o    = win_a;
          alu_b_o    = win_b;
          alu_ctrl_o = win_ctrl;
        end
        if (slot_free && !flush_i && any_valid) begin
          grant        = 1'b1;
          req0_ready_o = !win;
          req1_ready_o = win;
          if (win_ctrl == CTRL_MUL) begin
            hold_load = 1'b1;
            count_nxt = MUL_INIT;
            state_nxt = MUL_BUSY;
          end else begin
            load_res = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        // Operands stay on the ALU for the whole multicycle path, including stall cycles.
        alu_a_o    = hold_a;
        alu_b_o    = hold_b;
        alu_ctrl_o = hold_ctrl;
        load_tag   = hold_tag;
        load_src   = hold_src;
        if (count > 4'd1) begin
          count_nxt = count - 4'd1;
        end else if (slot_free) begin
          load_res  = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      count_nxt = '0;
      grant     = 1'b0;
      load_res  = 1'b0;
      hold_load = 1'b0;
    end
  end

  // State, multiply countdown and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (grant) begin
        last_grant <= win;
      end
    end
  end

  // Capture the multiply operands so the ALU inputs stay stable while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a    <= '0;
      hold_b    <= '0;
      hold_ctrl <= '0;
      hold_tag  <= '0;
      hold_src  <= 1'b0;
    end else if (hold_load) begin
      hold_a    <= win_a;
      hold_b    <= win_b;
      hold_ctrl <= win_ctrl;
      hold_tag  <= win_tag;
      hold_src  <= win;
    end
  end

  // One-entry output register: load wins over drain, flush kills the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_zero_o  <= 1'b0;
      res_tag_o   <= '0;
      res_src_o   <= 1'b0;
    end else if (flush_i) begin
      res_valid_o <= 1'b0;
    end else if (load_res) begin
      res_valid_o <= 1'b1;
      res_data_o  <= alu_result_i;
      res_zero_o  <= alu_zero_i;
      res_tag_o   <= load_tag;
      res_src_o   <= load_src;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule
